// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - single-issue fetch sequencer driving the program counter control interface
//
// Fetches the instruction at pc_in, hands it to decode, and resolves JMP, BRZ
// and HALT locally by issuing a one-cycle pc_control pulse to the PC.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   run                 start fetching from IDLE
//   pc_in               current PC from the program counter
//   cond_flag           condition flag, sampled at the decode handshake
//   imem_req_*          fetch request (valid/addr out, ready in)
//   imem_rsp_*          fetch response (valid pulse + data in)
//   instr_*             instruction to decode (valid/data/pc out, ready in)
//   pc_control          00 hold, 01 increment, 10 branch, 11 jump
//   branch_addr         registered BRZ target
//   jump_addr           registered JMP target
//   halted              HALT fetched; terminal until reset
module fetch_sequencer #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               cond_flag,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic [1:0]         pc_control,
  output logic [ADDR_W-1:0]  branch_addr,
  output logic [ADDR_W-1:0]  jump_addr,
  output logic               halted
);

  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_BRZ  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] PC_HOLD   = 2'b00;
  localparam logic [1:0] PC_INC    = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_UPDATE,
    S_HALT
  } state_t;

  state_t state, state_next;

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic [ADDR_W-1:0]  branch_q;
  logic [ADDR_W-1:0]  jump_q;
  logic [1:0]         ctl_q;
  logic               halted_q;

  logic [3:0]         rsp_op;
  logic [3:0]         cur_op;
  logic [ADDR_W-1:0]  operand;
  logic [1:0]         ctl_decision;
  logic               req_fire;
  logic               rsp_fire;
  logic               issue_fire;

  assign rsp_op  = imem_rsp_data[INSTR_W-1 -: 4];
  assign cur_op  = instr_q[INSTR_W-1 -: 4];
  assign operand = instr_q[ADDR_W-1:0];

  // Only the WAIT state listens to the response, so stray pulses (including
  // one coinciding with the request handshake) never reach instr_q.
  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    imem_req_addr  = '0;
    instr_valid    = 1'b0;
    req_fire       = 1'b0;
    rsp_fire       = 1'b0;
    issue_fire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_next = S_REQ;
      end
      S_REQ: begin
        // pc_in only changes at the end of UPDATE, so the address is stable here.
        imem_req_valid = 1'b1;
        imem_req_addr  = pc_in;
        if (imem_req_ready) begin
          req_fire   = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          rsp_fire   = 1'b1;
          state_next = (rsp_op == OP_HALT) ? S_HALT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          issue_fire = 1'b1;
          state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        state_next = S_REQ;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ctl_decision = PC_INC;
    case (cur_op)
      OP_JMP:  ctl_decision = PC_JUMP;
      OP_BRZ:  ctl_decision = cond_flag ? PC_BRANCH : PC_INC;
      default: ctl_decision = PC_INC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q    <= '0;
      instr_pc_q <= '0;
      branch_q   <= '0;
      jump_q     <= '0;
      ctl_q      <= PC_HOLD;
      halted_q   <= 1'b0;
    end else begin
      // Loaded only on the decode handshake, so the pulse lasts exactly the UPDATE cycle.
      ctl_q <= issue_fire ? ctl_decision : PC_HOLD;
      if (req_fire) begin
        instr_pc_q <= pc_in;
      end
      if (rsp_fire) begin
        instr_q <= imem_rsp_data;
        if (rsp_op == OP_HALT) halted_q <= 1'b1;
      end
      if (issue_fire) begin
        if (cur_op == OP_JMP) jump_q <= operand;
        // pc_in still holds this instruction's PC; the sum wraps mod 2^ADDR_W.
        if (cur_op == OP_BRZ) branch_q <= pc_in + operand;
      end
    end
  end

  assign instr_data  = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_control  = ctl_q;
  assign branch_addr = branch_q;
  assign jump_addr   = jump_q;
  assign halted      = halted_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the program counter's control interface: fetches the instruction at the current PC from instruction memory, hands it to decode, and issues pc_control, branch_addr and jump_addr back to the PC.
- Resolves JMP, BRZ and HALT locally. All other opcodes advance sequentially.
- Sits between the PC register, the instruction-memory port and the decode stage. One instruction is in flight at a time.

Parameters:
ADDR_W, 24, PC and address width (matches pc_out width)
INSTR_W, 32, instruction width; opcode = instr[INSTR_W-1:INSTR_W-4], operand = instr[ADDR_W-1:0]

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
run  input  1  start fetching from IDLE
pc_in  input  ADDR_W  current PC value (from program counter pc_out)
cond_flag  input  1  zero/condition flag from execute, sampled at the issue handshake
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  ADDR_W  fetch address
imem_req_ready  input  1  memory accepts request
imem_rsp_valid  input  1  fetch data valid (one-cycle pulse)
imem_rsp_data  input  INSTR_W  fetched instruction
instr_valid  output  1  instruction available to decode
instr_data  output  INSTR_W  instruction to decode
instr_pc  output  ADDR_W  PC of instr_data
instr_ready  input  1  decode accepts instruction
pc_control  output  2  00 hold, 01 increment, 10 branch, 11 jump (to program counter)
branch_addr  output  ADDR_W  branch target
jump_addr  output  ADDR_W  jump target
halted  output  1  HALT reached

Behaviour:
- Reset: reset is sampled on the clk edge while low. It forces state IDLE and sets every output to 0, including pc_control = 00 and halted = 0. Any outstanding fetch is abandoned.
- Opcodes:
  - 4'hA JMP: jump_addr = operand.
  - 4'hB BRZ: branch_addr = (pc_in + operand) mod 2^ADDR_W. The branch is taken only if cond_flag = 1; otherwise the PC increments.
  - 4'hF HALT.
  - All other opcodes increment the PC.
- State IDLE: outputs idle. Move to REQ on a cycle with run = 1.
- State REQ:
  - imem_req_valid = 1 and imem_req_addr = pc_in, held stable until imem_req_ready = 1.
  - On the handshake edge, capture the address into instr_pc and move to WAIT.
- State WAIT:
  - Wait for imem_rsp_valid. On the edge where it is 1, capture imem_rsp_data.
  - If the opcode is HALT: move to HALT, set halted = 1, pc_control stays 00, and the instruction is not presented to decode.
  - Otherwise move to ISSUE.
- State ISSUE:
  - instr_valid = 1, with instr_data and instr_pc held stable until instr_ready = 1.
  - On the handshake edge:
    - Register the pc_control decision from the opcode and cond_flag sampled at that edge.
    - Register branch_addr or jump_addr alongside it.
    - Clear instr_valid and move to UPDATE.
- State UPDATE:
  - pc_control is non-zero for exactly this one cycle, and the program counter updates at the end of it.
  - Next edge: pc_control returns to 00 and the state moves to REQ.
- State HALT: terminal. Only reset leaves it.
- pc_control is 00 in every state except UPDATE. The target outputs hold their last value outside UPDATE.
- Latency: at best 4 cycles per instruction (REQ, WAIT, ISSUE, UPDATE), with ready asserted and the response arriving on the cycle after the request handshake.
- Boundaries:
  - imem_rsp_valid outside WAIT is ignored.
  - A response arriving in the same cycle as the request handshake is ignored; it is not legal from memory.
  - run deasserted after leaving IDLE has no effect.
  - PC 0xFFFFFF increments to 0x000000; the program counter performs the wrap.
  - A BRZ target overflow wraps mod 2^24, e.g. 0xFFFFF0 + 0x000020 = 0x000010.
  - Reset low in any state, including mid-REQ with ready low, returns to IDLE on that edge with all outputs 0.

Test Plan:
- Reset low 2 cycles, then high with run = 0 -> all outputs 0, state IDLE; stays idle 10 cycles.
- run = 1, pc_in = 0x000010, zero-wait memory returning 0x12345678, instr_ready = 1 -> req_addr = 0x000010; instr_valid with instr_pc = 0x000010; exactly one cycle of pc_control = 01; next req_addr = 0x000011; 4-cycle cadence.
- JMP 0xA0ABCDEF -> jump_addr = 0xABCDEF with one cycle of pc_control = 11. BRZ 0xB0000020 at pc 0xFFFFF0 with cond_flag = 1 -> branch_addr = 0x000010, pc_control = 10. Same BRZ with cond_flag = 0 -> pc_control = 01.
- imem_req_ready low 5 cycles, then a 3-cycle response delay, then instr_ready low 4 cycles -> request and instr outputs stay stable throughout; pc_control stays 00 until the handshake; a stray rsp_valid pulse during REQ is ignored.
- Fetch of 0xF0000000 -> halted = 1, instr_valid never asserted, pc_control stays 00 for 20 cycles. Reset low then returns to IDLE with halted = 0.
- Reset asserted mid-WAIT and mid-UPDATE -> outputs 0 on that edge with no further pc_control pulse; after release, the sequence restarts from IDLE.
